// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the 3-stage RV32 pipeline: PC-source select
//   encodings, the canonical NOP, the fetch-stage state type and the base
//   opcode constants that decode switches on.
//   No ports; imported with "import riscv_pkg::*;".
package riscv_pkg;

  // PC-source select driven by control into the fetch stage.
  localparam logic [1:0] PC_REPLAY = 2'd0;
  localparam logic [1:0] PC_PLUS4  = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;
  localparam logic [1:0] PC_BRANCH = 2'd3;

  // addi x0,x0,0 -- what decode sees during a bubble.
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Fetch-stage states.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetchState_e;

  // RV32I base opcodes (inst[6:0]) used by decode.
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Both taken-control-transfer encodings share the upper select bit.
  function automatic logic isRedirect(input logic [1:0] pcSrc);
    return pcSrc[1];
  endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// fetch_pc_sel
//   Combinational next-PC priority mux for the fetch stage.
//   Priority (highest first): branch/JAL target, JALR target with bit 0
//   cleared, stall (hold), replay (hold), sequential PC+4 (wraps mod 2^32).
// Ports:
//   pcSrc      in  2   PC-source select (riscv_pkg PC_* encodings)
//   stall      in  1   hold the current PC unless redirected
//   pcF        in  32  current fetch PC
//   brTarget   in  32  branch/JAL target
//   jalrTarget in  32  JALR target (bit 0 ignored)
//   nextPc     out 32  PC to fetch on the next edge
module fetch_pc_sel
  import riscv_pkg::*;
(
  input  logic [1:0]  pcSrc,
  input  logic        stall,
  input  logic [31:0] pcF,
  input  logic [31:0] brTarget,
  input  logic [31:0] jalrTarget,
  output logic [31:0] nextPc
);

  // Redirects beat a decode stall: the stalled instruction is on the wrong
  // path once control has resolved a taken transfer.
  always_comb begin
    nextPc = pcF;
    if (pcSrc == PC_BRANCH) begin
      nextPc = brTarget;
    end else if (pcSrc == PC_JALR) begin
      nextPc = jalrTarget & 32'hFFFF_FFFE;
    end else if (stall) begin
      nextPc = pcF;
    end else if (pcSrc == PC_REPLAY) begin
      nextPc = pcF;
    end else begin
      nextPc = pcF + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of the 3-stage RV32 pipeline. Owns the PC,
//   drives a synchronous-read instruction memory and hands the instruction,
//   its PC and a valid bit to decode. Redirects and replays produce one NOP
//   bubble; decode stalls park the instruction in a holding register.
//
//   Optional feature macro: FETCH_PERF_CNT_EN
//     defined   -> fetch_cnt / bubble_cnt are live 32-bit wrapping counters
//     undefined -> both ports are tied to zero
//
// Ports:
//   clk          in  1   rising-edge clock
//   rst          in  1   asynchronous active-high reset
//   pc_src       in  2   0 replay, 1 PC+4, 2 JALR, 3 branch/JAL
//   stall_D      in  1   decode cannot accept the current instruction
//   br_target    in  32  branch/JAL target
//   jalr_target  in  32  JALR target
//   imem_addr    out 32  word-aligned fetch address
//   imem_re      out 1   memory read enable
//   imem_rdata   in  32  memory data, one cycle after the address
//   inst_D       out 32  instruction to decode
//   pc_D         out 32  PC of inst_D
//   valid_D      out 1   inst_D is a real instruction
//   fetch_cnt    out 32  instructions accepted by decode
//   bubble_cnt   out 32  bubble cycles seen by decode
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = RV_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_src,
  input  logic        stall_D,
  input  logic [31:0] br_target,
  input  logic [31:0] jalr_target,
  output logic [31:0] imem_addr,
  output logic        imem_re,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_D,
  output logic [31:0] pc_D,
  output logic        valid_D,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  fetchState_e state;
  fetchState_e stateNext;
  logic [31:0] pcF;
  logic [31:0] nextPc;
  logic        validQ;
  logic        validNext;
  logic [31:0] holdQ;
  logic        captureHold;
  logic        redirect;
  logic [1:0]  selSrc;
  logic        selStall;

  assign redirect = isRedirect(pc_src);

  // The word that arrives during BOOT or a bubble cycle is thrown away, so
  // the PC that is presented next must be fetched again: those cycles steer
  // the mux to replay unless a redirect arrives (BOOT ignores even that).
  always_comb begin
    selSrc   = pc_src;
    selStall = stall_D;
    if (state == BOOT) begin
      selSrc   = PC_REPLAY;
      selStall = 1'b0;
    end else if (!validQ && !redirect) begin
      selSrc = PC_REPLAY;
    end
  end

  fetch_pc_sel pcSel (
    .pcSrc      (selSrc),
    .stall      (selStall),
    .pcF        (pcF),
    .brTarget   (br_target),
    .jalrTarget (jalr_target),
    .nextPc     (nextPc)
  );

  assign imem_addr = {nextPc[31:2], 2'b00};

  // The memory is idle only while an instruction stays parked in HOLD; the
  // cycle that leaves HOLD already fetches the next word.
  assign imem_re = !((state == HOLD) && stall_D && !redirect);

  // Next-state logic. validQ marks whether the word arriving after the edge
  // belongs to the PC being presented; a stall entered during a bubble keeps
  // the bubble rather than parking a NOP.
  always_comb begin
    stateNext   = state;
    validNext   = validQ;
    captureHold = 1'b0;
    case (state)
      BOOT: begin
        stateNext = RUN;
        validNext = 1'b1;
      end
      RUN, HOLD: begin
        if (redirect) begin
          stateNext = RUN;
          validNext = 1'b0;
        end else if (!validQ) begin
          stateNext = RUN;
          validNext = !stall_D;
        end else if (stall_D) begin
          stateNext   = HOLD;
          validNext   = 1'b1;
          captureHold = (state == RUN);
        end else begin
          stateNext = RUN;
          validNext = (pc_src != PC_REPLAY);
        end
      end
      default: begin
        stateNext = BOOT;
        validNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= BOOT;
      pcF    <= RESET_PC;
      validQ <= 1'b0;
      holdQ  <= 32'd0;
    end else begin
      state  <= stateNext;
      pcF    <= nextPc;
      validQ <= validNext;
      if (captureHold) begin
        holdQ <= imem_rdata;
      end
    end
  end

  // In HOLD the memory output is no longer the parked word (the read enable
  // is dropped), so the instruction comes from holdQ, including the release
  // cycle in which decode finally takes it.
  always_comb begin
    inst_D = imem_rdata;
    if (!validQ) begin
      inst_D = NOP_INST;
    end else if (state == HOLD) begin
      inst_D = holdQ;
    end
  end

  assign pc_D    = pcF;
  assign valid_D = validQ;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCnt;
  logic [31:0] bubbleCnt;

  // Accepted instructions and post-boot bubbles, both free-running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchCnt  <= 32'd0;
      bubbleCnt <= 32'd0;
    end else begin
      if (validQ && !stall_D) begin
        fetchCnt <= fetchCnt + 32'd1;
      end
      if (!validQ && (state != BOOT)) begin
        bubbleCnt <= bubbleCnt + 32'd1;
      end
    end
  end

  assign fetch_cnt  = fetchCnt;
  assign bubble_cnt = bubbleCnt;
`else
  assign fetch_cnt  = 32'd0;
  assign bubble_cnt = 32'd0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 3-stage RV32 pipeline, directly upstream of the control/decode logic.
- Owns the PC register and drives a synchronous-read instruction memory.
- Consumes the 2-bit PC-source select, branch/JAL/JALR targets and decode stall.
- Presents the instruction, its PC and a valid bit to decode; inserts NOP bubbles on redirect and replay.

Parameters:
- RESET_PC, 32'h0000_2000, byte address of the first fetch after reset.
- NOP_INST, 32'h0000_0013, instruction driven to decode during a bubble (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- pc_src  in  2  0=replay current PC, 1=PC+4, 2=JALR target, 3=branch/JAL target.
- stall_D  in  1  decode cannot accept; hold fetch and decode outputs.
- br_target  in  32  branch/JAL target, valid when pc_src==3.
- jalr_target  in  32  JALR target, valid when pc_src==2.
- imem_addr  out  32  byte address to instruction memory; bits[1:0] always 00.
- imem_re  out  1  read enable.
- imem_rdata  in  32  read data, valid one cycle after address.
- inst_D  out  32  instruction to decode.
- pc_D  out  32  PC of inst_D.
- valid_D  out  1  inst_D is a real instruction.
- fetch_cnt  out  32  retired-fetch counter; see Optional Feature.
- bubble_cnt  out  32  bubble counter; see Optional Feature.

Behaviour:
- Interface: one clock (clk); asynchronous active-high reset (rst).
- States: BOOT, RUN, HOLD.
- Reset (async assert):
  - state=BOOT, pc_F=RESET_PC, valid_q=0, hold_q=0.
  - inst_D=NOP_INST, pc_D=RESET_PC, valid_D=0.
  - imem_addr=RESET_PC, imem_re=1.
  - Counters=0.
- Reset release is synchronous to clk.
- BOOT:
  - One cycle; next_pc=pc_F.
  - Next state RUN with valid_q=1.
  - First valid instruction = mem[RESET_PC], available one cycle after the first edge.
- next_pc priority (highest first):
  - (1) pc_src==3 -> br_target.
  - (2) pc_src==2 -> {jalr_target[31:1],1'b0}.
  - (3) stall_D -> pc_F.
  - (4) pc_src==0 -> pc_F.
  - (5) pc_src==1 -> pc_F+4, mod 2^32, wraps silently.
- Memory addressing:
  - imem_addr = {next_pc[31:2],2'b00}, combinational.
  - pc_F <= next_pc every edge.
  - imem_re=0 only in HOLD.
- Redirect (pc_src[1]=1):
  - Overrides stall_D.
  - Next cycle: valid_D=0, inst_D=NOP_INST, pc_D=target.
  - The wrong-path word returned that cycle is discarded.
- Replay (pc_src==0, no stall):
  - Refetch pc_F; the following cycle is a bubble (valid_D=0).
  - Used for load-use.
- Stall (stall_D=1, no redirect):
  - RUN->HOLD; hold_q captures imem_rdata on the first stall edge.
  - inst_D, pc_D and valid_D are held stable for the full stall.
  - Leaving HOLD: inst_D from hold_q for one cycle, then memory resumes at pc_F+4.
- Redirect during HOLD: discard hold_q, go to RUN, bubble as above.
- inst_D source mux: BOOT/bubble -> NOP_INST; HOLD or first cycle after HOLD -> hold_q; otherwise imem_rdata.
- Reset mid-stall or mid-redirect: state and outputs return to reset values immediately; no stale valid_D.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - fetch_cnt increments on each cycle valid_D=1 and stall_D=0.
  - bubble_cnt increments on each cycle valid_D=0 outside BOOT.
  - Both 32-bit, wrap, cleared by rst.
- Undefined: both ports tied to 32'd0; no counter flops synthesized.

Decomposition:
- Shared package riscv_pkg:
  - pc_src encodings: PC_REPLAY=0, PC_PLUS4=1, PC_JALR=2, PC_BRANCH=3.
  - NOP constant 32'h0000_0013.
  - fetch state enum BOOT/RUN/HOLD.
  - Opcode constants used by decode.
- One natural sub-module: fetch_pc_sel, the combinational next_pc priority mux, testable in isolation.
- Counters stay inline.

Test Plan:
- Reset RESET_PC=0x2000, pc_src=1 thereafter:
  - imem_addr 0x2000 during reset and BOOT.
  - valid_D rises one cycle after BOOT.
  - pc_D sequence 0x2000, 0x2004, 0x2008.
- At pc_F=0x2008, pc_src=3, br_target=0x2100:
  - Next cycle valid_D=0, inst_D=0x00000013.
  - Then pc_D=0x2100, valid_D=1.
- stall_D high 3 cycles with inst_D=0x00a00093 at pc_D=0x2004:
  - inst_D/pc_D/valid_D constant for all 3 cycles.
  - After release, 0x2008 follows with no lost or duplicated instruction.
- stall_D=1 and pc_src=2, jalr_target=0x3001 in the same cycle:
  - Redirect wins; imem_addr=0x3000.
  - One bubble, then pc_D=0x3000.
- pc_src=0 for one cycle at pc_F=0x200C:
  - Bubble, then 0x200C re-presented with valid_D=1.
- rst asserted mid-HOLD:
  - Outputs immediately valid_D=0, inst_D=NOP, imem_addr=0x2000.
  - With FETCH_PERF_CNT_EN, counters read 0.
